sr_latch_ctrl: RTL and testbench

Sequencer that writes and reads back a bank of N gated SR latches (S, R shared; per-latch enable E; per-latch Q). It accepts set/reset/read commands over a valid/ready interface. For each command it generates the S/R setup, E pulse and S/R hold timing, then samples the synchronised Q and returns a checked response. It sits between a synchronous host/test sequencer and the asynchronous latch bank, and guarantees the forbidden S=R=1 input is never driven.

---
 rtl/sr_latch_ctrl.sv | 145 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - write/read-back sequencer for a bank of gated SR latches
module sr_latch_ctrl #(
  parameter int N          = 4,
  parameter int IDX_W      = 2,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             lat_s,
  output logic             lat_r,
  output logic [N-1:0]     lat_e,
  input  logic [N-1:0]     lat_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_q,
  output logic             rsp_err,
  output logic             busy
);

  if (N < 1 || N > 16 || (2 ** IDX_W) < N ||
      SETUP_CYC < 1 || SETUP_CYC > 255 || PULSE_CYC < 1 || PULSE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255 || SETTLE_CYC < 3 || SETTLE_CYC > 255) begin : g_param_err
    $error("sr_latch_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  state_t             state;
  logic [7:0]         cnt;
  logic [1:0]         op_r;
  logic [IDX_W-1:0]   idx_r;
  logic [N-1:0]       sync1, sync2;
  logic [N-1:0]       idx_onehot;
  logic               q_sel;
  logic               idx_ok;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign idx_onehot = N'(1) << idx_r;
  assign q_sel      = |(sync2 & idx_onehot);
  assign idx_ok     = {1'b0, cmd_idx} < (IDX_W + 1)'(N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= OP_READ;
      idx_r     <= '0;
      sync1     <= '0;
      sync2     <= '0;
      lat_s     <= 1'b0;
      lat_r     <= 1'b0;
      lat_e     <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      sync1 <= lat_q;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r  <= cmd_op;
            idx_r <= cmd_idx;
            if (cmd_op == OP_ILL || !idx_ok) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_q     <= 1'b0;
              state     <= RESP;
            end else if (cmd_op == OP_READ) begin
              cnt   <= 8'(SETTLE_CYC - 1);
              state <= SETTLE;
            end else begin
              // S and R come from a single decoded op, so both can never be high together
              lat_s <= (cmd_op == OP_SET);
              lat_r <= (cmd_op == OP_RESET);
              cnt   <= 8'(SETUP_CYC - 1);
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            lat_e <= idx_onehot;
            cnt   <= 8'(PULSE_CYC - 1);
            state <= PULSE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            lat_e <= '0;
            cnt   <= 8'(HOLD_CYC - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            lat_s <= 1'b0;
            lat_r <= 1'b0;
            cnt   <= 8'(SETTLE_CYC - 1);
            state <= SETTLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            rsp_valid <= 1'b1;
            rsp_q     <= q_sel;
            rsp_err   <= (op_r == OP_SET && !q_sel) || (op_r == OP_RESET && q_sel);
            state     <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - directed bench for sr_latch_ctrl with a behavioural latch bank
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_ready, lat_s, lat_r, rsp_valid, rsp_ready, rsp_q, rsp_err, busy;
  logic [1:0] cmd_op, cmd_idx;
  logic [3:0] lat_e, lat_q;

  logic       c3_cmd_valid, c3_cmd_ready, c3_lat_s, c3_lat_r, c3_rsp_valid, c3_rsp_ready;
  logic       c3_rsp_q, c3_rsp_err, c3_busy;
  logic [1:0] c3_cmd_op, c3_cmd_idx;
  logic [2:0] c3_lat_e;
  logic [2:0] c3_lat_q = 3'b000;

  sr_latch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .lat_s(lat_s), .lat_r(lat_r),
    .lat_e(lat_e), .lat_q(lat_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
  );

  sr_latch_ctrl #(.N(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
    .cmd_op(c3_cmd_op), .cmd_idx(c3_cmd_idx), .lat_s(c3_lat_s), .lat_r(c3_lat_r),
    .lat_e(c3_lat_e), .lat_q(c3_lat_q), .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready),
    .rsp_q(c3_rsp_q), .rsp_err(c3_rsp_err), .busy(c3_busy)
  );

  // Gated SR latch bank; stuck bits force the observed Q to 0
  logic [3:0] q_mem = 4'b0000;
  logic [3:0] stuck = 4'b0000;
  always @(lat_s or lat_r or lat_e) begin
    for (int i = 0; i < 4; i++) begin
      if (lat_e[i]) begin
        if (lat_s) q_mem[i] = 1'b1;
        else if (lat_r) q_mem[i] = 1'b0;
      end
    end
  end
  assign lat_q = q_mem & ~stuck;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         lat_n, s_cnt, r_cnt, e_cnt, s_first, r_first, e_first, bad;
  logic [3:0] e_seen;

  // Present a command at a falling edge and track latch drive until rsp_valid or timeout
  task automatic issue(input logic [1:0] op, input logic [1:0] idx);
    logic ps, pr;
    logic [3:0] pe;
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
    s_cnt = 0; r_cnt = 0; e_cnt = 0; s_first = 0; r_first = 0; e_first = 0; bad = 0;
    e_seen = 4'b0000; ps = 1'b0; pr = 1'b0; pe = 4'b0000; n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (lat_s) begin s_cnt++; if (s_first == 0) s_first = n; end
      if (lat_r) begin r_cnt++; if (r_first == 0) r_first = n; end
      if (lat_e != 4'b0000) begin e_cnt++; e_seen |= lat_e; if (e_first == 0) e_first = n; end
      if (lat_s && lat_r) bad++;
      if ((lat_e & (lat_e - 4'd1)) != 4'b0000) bad++;
      if (lat_e != 4'b0000 && pe != 4'b0000 && (lat_s != ps || lat_r != pr)) bad++;
      ps = lat_s; pr = lat_r; pe = lat_e;
      if (rsp_valid) break;
    end
    lat_n = n;
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_ready"}, cmd_ready, 1'b1);
    check({tag, "_vclr"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = 2'b00; rsp_ready = 1'b0;
    c3_cmd_valid = 1'b0; c3_cmd_op = 2'b00; c3_cmd_idx = 2'b00; c3_rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_drive", {lat_s, lat_r, lat_e}, 6'b0);
    check("rst_rsp", {rsp_valid, rsp_q, rsp_err, busy}, 4'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // READ of a cleared latch
    issue(2'b00, 2'd0);
    check("rd0_lat", lat_n, 4);
    check("rd0_rsp", {rsp_q, rsp_err}, 2'b00);
    check("rd0_drive", s_cnt + r_cnt + e_cnt, 0);
    take_rsp("rd0");

    // SET idx2
    issue(2'b01, 2'd2);
    check("set2_lat", lat_n, 12);
    check("set2_s_cnt", s_cnt, 8);
    check("set2_s_first", s_first, 1);
    check("set2_r_cnt", r_cnt, 0);
    check("set2_e_cnt", e_cnt, 4);
    check("set2_e_first", e_first, 3);
    check("set2_e_seen", e_seen, 4'b0100);
    check("set2_inv", bad, 0);
    check("set2_rsp", {rsp_q, rsp_err}, 2'b10);
    take_rsp("set2");

    issue(2'b00, 2'd2);
    check("rd2a_lat", lat_n, 4);
    check("rd2a_rsp", {rsp_q, rsp_err}, 2'b10);
    take_rsp("rd2a");

    // RESET idx2
    issue(2'b10, 2'd2);
    check("rst2_lat", lat_n, 12);
    check("rst2_r_cnt", r_cnt, 8);
    check("rst2_r_first", r_first, 1);
    check("rst2_s_cnt", s_cnt, 0);
    check("rst2_e", {e_cnt[3:0], e_seen}, {4'd4, 4'b0100});
    check("rst2_e_first", e_first, 3);
    check("rst2_inv", bad, 0);
    check("rst2_rsp", {rsp_q, rsp_err}, 2'b00);
    take_rsp("rst2");

    issue(2'b00, 2'd2);
    check("rd2b_rsp", {rsp_q, rsp_err}, 2'b00);
    take_rsp("rd2b");

    // Illegal op
    issue(2'b11, 2'd1);
    check("ill_lat", lat_n, 1);
    check("ill_rsp", {rsp_q, rsp_err}, 2'b01);
    check("ill_drive", s_cnt + r_cnt + e_cnt, 0);
    take_rsp("ill");

    // Out-of-range index on the N=3 instance
    c3_cmd_valid = 1'b1; c3_cmd_op = 2'b01; c3_cmd_idx = 2'd3;
    @(negedge clk);
    c3_cmd_valid = 1'b0;
    check("n3_rsp", {c3_rsp_valid, c3_rsp_q, c3_rsp_err}, 3'b101);
    check("n3_drive", {c3_lat_s, c3_lat_r, c3_lat_e}, 5'b0);
    check("n3_busy", c3_busy, 1'b1);
    c3_rsp_ready = 1'b1;
    @(negedge clk);
    c3_rsp_ready = 1'b0;
    check("n3_ready", c3_cmd_ready, 1'b1);

    // Backpressure with stray command pulses
    issue(2'b01, 2'd0);
    check("bp_lat", lat_n, 12);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0); cmd_op = 2'b00; cmd_idx = 2'd1;
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_q, rsp_err, cmd_ready}, 4'b1100);
    end
    cmd_valid = 1'b0;
    take_rsp("bp");
    @(negedge clk);
    check("bp_idle", busy, 1'b0);

    // Stuck-at-0 Q on idx1
    stuck = 4'b0010;
    issue(2'b01, 2'd1);
    check("stk_lat", lat_n, 12);
    check("stk_rsp", {rsp_q, rsp_err}, 2'b01);
    take_rsp("stk");
    stuck = 4'b0000;

    // Reset during PULSE
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 2'd3;
    cnt = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cnt++;
    end while (lat_e == 4'b0000 && cnt < 20);
    check("mid_pulse_e", lat_e, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_drive", {lat_s, lat_r, lat_e}, 6'b0);
    check("mid_rst_ready", {cmd_ready, busy, rsp_valid}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("mid_no_rsp", cnt, 0);
    check("mid_ready", cmd_ready, 1'b1);

    // Latch 3 kept the value it reached during the interrupted pulse
    issue(2'b00, 2'd3);
    check("rd3_rsp", {rsp_q, rsp_err}, 2'b10);
    take_rsp("rd3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
